// File: rtl/instr_asm.sv
// instr_asm: turns decoded MIPS commands (op class + fields) into 32-bit machine words with IM byte addresses.
// Latency: one cycle from command accept to out_valid; one word per cycle sustained while out_ready stays high.
// Backpressure: single output register; cmd_ready drops while the held word stalls, in SLOT, or when IM capacity is reached.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op selects the operation (13-15 illegal)
//   cmd_rs/rt/rd/imm/target    instruction fields, unused ones ignored per op
//   out_valid/out_ready        output word handshake; out_instr/out_addr held stable while stalled
//   full                       IM_WORDS words emitted, no more commands until reset
//   err                        sticky, set by an illegal cmd_op
// Build option: define INSTR_ASM_DELAY_SLOT_EN to auto-insert a nop after beq/j/jal/jr/jalr.
module instr_asm #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int          IM_WORDS  = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [4:0]  cmd_rs,
   input  logic [4:0]  cmd_rt,
   input  logic [4:0]  cmd_rd,
   input  logic [15:0] cmd_imm,
   input  logic [25:0] cmd_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        full,
   output logic        err
);

   // 17 bits so the counter can reach IM_WORDS = 65535 and still hold count + 2.
   localparam int            CW   = 17;
   localparam logic [CW-1:0] IM_W = CW'(IM_WORDS);

`ifdef INSTR_ASM_DELAY_SLOT_EN
   typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SLOT} state_t;
`else
   typedef enum logic [1:0] {S_EMPTY, S_FULL} state_t;
`endif

   state_t        state_q, state_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   addr_q,  addr_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          err_q,   err_d;

   logic [31:0]   enc_word;
   logic          enc_illegal;
   logic          held;
   logic [CW-1:0] cnt_used;
   logic          room;
   logic          out_hs;
   logic          accept;

`ifdef INSTR_ASM_DELAY_SLOT_EN
   logic          br_q, br_d;
   logic          is_branch;
   assign is_branch = (cmd_op >= 4'd8) && (cmd_op <= 4'd12);
`endif

   // Field packing; illegal ops fall through to the all-zero word.
   always_comb begin
      enc_word    = 32'h0;
      enc_illegal = 1'b0;
      case (cmd_op)
         4'd0:    enc_word = 32'h0;
         4'd1:    enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h21};
         4'd2:    enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h23};
         4'd3:    enc_word = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h25};
         4'd4:    enc_word = {6'h0D, cmd_rs, cmd_rt, cmd_imm};
         4'd5:    enc_word = {6'h0F, 5'd0,   cmd_rt, cmd_imm};
         4'd6:    enc_word = {6'h23, cmd_rs, cmd_rt, cmd_imm};
         4'd7:    enc_word = {6'h2B, cmd_rs, cmd_rt, cmd_imm};
         4'd8:    enc_word = {6'h04, cmd_rs, cmd_rt, cmd_imm};
         4'd9:    enc_word = {6'h02, cmd_target};
         4'd10:   enc_word = {6'h03, cmd_target};
         4'd11:   enc_word = {6'h00, cmd_rs, 15'd0, 6'h08};
         4'd12:   enc_word = {6'h00, cmd_rs, 5'd0, cmd_rd, 5'd0, 6'h09};
         default: enc_illegal = 1'b1;
      endcase
   end

   assign out_valid = (state_q != S_EMPTY);
   assign out_instr = instr_q;
   assign out_addr  = addr_q;
   assign full      = (cnt_q == IM_W);
   assign err       = err_q;
   assign out_hs    = out_valid && out_ready;

   // A held word is counted even if it drains this cycle, so the last slot is never overbooked.
   assign held     = (state_q != S_EMPTY);
   assign cnt_used = cnt_q + CW'(held);

`ifdef INSTR_ASM_DELAY_SLOT_EN
   // Branches reserve room for their trailing nop; a held branch blocks pass-through until its nop is out.
   assign room      = is_branch ? (cnt_used + CW'(2) <= IM_W) : (cnt_used < IM_W);
   assign cmd_ready = !full && room &&
                      ((state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready && !br_q));
`else
   assign room      = (cnt_used < IM_W);
   assign cmd_ready = !full && room &&
                      ((state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready));
`endif

   assign accept = cmd_valid && cmd_ready;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
`ifdef INSTR_ASM_DELAY_SLOT_EN
      br_d    = br_q;
`endif

      if (out_hs) begin
         cnt_d  = cnt_q + CW'(1);
         addr_d = addr_q + 32'd4;
      end

      case (state_q)
         S_EMPTY: begin
            if (accept) state_d = S_FULL;
         end
         S_FULL: begin
            if (out_hs && !accept) begin
`ifdef INSTR_ASM_DELAY_SLOT_EN
               if (br_q) begin
                  state_d = S_SLOT;
                  instr_d = 32'h0;
                  br_d    = 1'b0;
               end else begin
                  state_d = S_EMPTY;
               end
`else
               state_d = S_EMPTY;
`endif
            end
         end
`ifdef INSTR_ASM_DELAY_SLOT_EN
         S_SLOT: begin
            if (out_hs) state_d = S_EMPTY;
         end
`endif
         default: state_d = S_EMPTY;
      endcase

      // Loading is the same whether the register was empty or just drained.
      if (accept) begin
         instr_d = enc_word;
         err_d   = err_q | enc_illegal;
`ifdef INSTR_ASM_DELAY_SLOT_EN
         br_d    = is_branch;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         instr_q <= 32'h0;
         addr_q  <= BASE_ADDR;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef INSTR_ASM_DELAY_SLOT_EN
         br_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef INSTR_ASM_DELAY_SLOT_EN
         br_q    <= br_d;
`endif
      end
   end

endmodule

// File: tb/tb_instr_asm.sv
// tb_instr_asm: scoreboard bench for instr_asm; driver pushes expected words on accept, monitor pops on output handshake.
// Latency: expects each accepted command on the output one cycle later, plus a nop after branches in delay-slot builds.
// Backpressure: out_ready is either forced by directed sections or randomized each cycle.
module tb_instr_asm;

   localparam logic [31:0] BASE = 32'h0000_3000;
`ifdef INSTR_ASM_DELAY_SLOT_EN
   localparam bit SLOT_EN = 1'b1;
`else
   localparam bit SLOT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [4:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
   logic [15:0] cmd_imm = '0;
   logic [25:0] cmd_target = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr, out_addr;
   logic        full, err;

   logic        s_cmd_valid = 1'b0;
   logic        s_cmd_ready;
   logic        s_out_valid;
   logic [31:0] s_out_instr, s_out_addr;
   logic        s_full, s_err;

   int n_pass = 0;
   int n_total = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;
   exp_t exp_q[$];
   int   widx = 0;
   logic model_err = 1'b0;

   logic rnd_rdy = 1'b0;
   logic rdy_force = 1'b1;

   instr_asm #(.BASE_ADDR(BASE), .IM_WORDS(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
      .cmd_imm(cmd_imm), .cmd_target(cmd_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .full(full), .err(err)
   );

   instr_asm #(.BASE_ADDR(BASE), .IM_WORDS(2)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(4'd1),
      .cmd_rs(5'd1), .cmd_rt(5'd2), .cmd_rd(5'd3),
      .cmd_imm(16'h0), .cmd_target(26'h0),
      .out_valid(s_out_valid), .out_ready(1'b1),
      .out_instr(s_out_instr), .out_addr(s_out_addr),
      .full(s_full), .err(s_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Reference encoder written from the field table with shifts and ORs.
   function automatic logic [31:0] ref_enc(input logic [31:0] op, input logic [31:0] rs,
                                           input logic [31:0] rt, input logic [31:0] rd,
                                           input logic [31:0] imm, input logic [31:0] tgt);
      logic [31:0] r, i;
      r = (rs << 21) | (rt << 16) | (rd << 11);
      i = (rs << 21) | (rt << 16) | imm;
      case (op)
         1:  return r | 32'h21;
         2:  return r | 32'h23;
         3:  return r | 32'h25;
         4:  return (32'h0D << 26) | i;
         5:  return (32'h0F << 26) | (rt << 16) | imm;
         6:  return (32'h23 << 26) | i;
         7:  return (32'h2B << 26) | i;
         8:  return (32'h04 << 26) | i;
         9:  return (32'h02 << 26) | tgt;
         10: return (32'h03 << 26) | tgt;
         11: return (rs << 21) | 32'h08;
         12: return (rs << 21) | (rd << 11) | 32'h09;
         default: return 32'h0;
      endcase
   endfunction

   function automatic void push_exp(input logic [31:0] w);
      exp_t e;
      e.instr = w;
      e.addr  = BASE + 32'(widx) * 32'd4;
      exp_q.push_back(e);
      widx++;
   endfunction

   // Drives one command and waits for acceptance; expected words are queued on the accepting edge.
   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic [31:0] exp, output int waits);
      cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm; cmd_target = tgt;
      cmd_valid = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) begin
            push_exp(exp);
            if (SLOT_EN && op >= 4'd8 && op <= 4'd12) push_exp(32'h0);
            if (op >= 4'd13) model_err = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            break;
         end
         waits++;
         if (waits > 500) begin
            fail_now("accept_timeout");
            cmd_valid = 1'b0;
            break;
         end
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) fail_now(name);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_instr"}, out_instr, 32'h0);
      chk({tag, "_out_addr"},  out_addr, BASE);
      chk({tag, "_full"},      32'(full), 32'd0);
      chk({tag, "_err"},       32'(err), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   // Monitor: whenever a word is presented it must match the oldest expected one; pop on handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_word: got %h at %h, expected no word", out_instr, out_addr);
         end else begin
            chk("out_instr", out_instr, exp_q[0].instr);
            chk("out_addr", out_addr, exp_q[0].addr);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tgt;
      int acc, hs;

      #12;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First word and its one-cycle latency.
      send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221821, w);
      @(negedge clk);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;

      // Back-to-back with no bubbles.
      send(4'd4, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h34011234, w);
      chk("b2b_wait_ori", w, 0);
      send(4'd5, 5'd5, 5'd8, 5'd0, 16'hABCD, 26'h0, 32'h3C08ABCD, w);
      chk("b2b_wait_lui", w, 0);
      send(4'd7, 5'd0, 5'd5, 5'd0, 16'h0004, 26'h0, 32'hAC050004, w);
      chk("b2b_wait_sw", w, 0);
      drain("drain_b2b");

      // Stalled branch: word held stable and commands refused.
      rdy_force = 1'b0;
      @(posedge clk);
      #1;
      send(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF, w);
      fork
         send(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000C00, 32'h0C000C00, w);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
               chk("stall_out_valid", 32'(out_valid), 32'd1);
            end
            rdy_force = 1'b1;
         end
      join
      drain("drain_branch");

      // Illegal op emits a zero word and sets the sticky error.
      send(4'd14, 5'd7, 5'd7, 5'd7, 16'h5555, 26'h3FFFFFF, 32'h0, w);
      drain("drain_illegal");
      chk("err_after_illegal", 32'(err), 32'd1);

      // Randomized stream with random backpressure.
      rnd_rdy = 1'b1;
      for (int n = 0; n < 300; n++) begin
         op  = 4'($urandom_range(0, 15));
         rs  = 5'($urandom);
         rt  = 5'($urandom);
         rd  = 5'($urandom);
         imm = 16'($urandom);
         tgt = 26'($urandom);
         send(op, rs, rt, rd, imm, tgt, ref_enc(32'(op), 32'(rs), 32'(rt), 32'(rd), 32'(imm), 32'(tgt)), w);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain("drain_random");
      rnd_rdy = 1'b0;
      rdy_force = 1'b1;
      chk("err_sticky_random", 32'(err), 32'(model_err));
      chk("full_low_random", 32'(full), 32'd0);

      // Capacity boundary on the 2-word instance.
      acc = 0;
      hs  = 0;
      s_cmd_valid = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (s_cmd_valid && s_cmd_ready) acc++;
         if (s_out_valid) hs++;
      end
      chk("cap_accepted", acc, 2 + (SLOT_EN ? 0 : 0));
      chk("cap_emitted", hs, 2);
      chk("cap_full", 32'(s_full), 32'd1);
      chk("cap_cmd_ready", 32'(s_cmd_ready), 32'd0);
      chk("cap_last_addr", s_out_addr, BASE + 32'd8);
      @(posedge clk);
      #1;
      s_cmd_valid = 1'b0;

      // Reset in the middle of a held word.
      rdy_force = 1'b0;
      @(posedge clk);
      #1;
      send(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h00853023, w);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      exp_q.delete();
      widx = 0;
      model_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rdy_force = 1'b1;
      @(posedge clk);
      #1;
      send(4'd4, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h34011234, w);
      drain("drain_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
